// File: rtl/chip_select_sched.sv
// Round-robin scheduler sharing one 3-to-8 active-low chip-select decoder.
// Each access runs SETUP (selects only), ACTIVE (decoder enabled), RECOVER (gap).
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_IDLE    | no access; arbitrate on req, latch winner and its sel
// ST_SETUP   | grant high, selects driven, decoder still disabled
// ST_ACTIVE  | grant high, decoder enabled for WAIT_CYC cycles
// ST_RECOVER | grant low, decoder disabled for GAP_CYC cycles, done on entry
module chip_select_sched #(
    parameter int NREQ     = 3,
    parameter int WAIT_CYC = 2,
    parameter int GAP_CYC  = 1
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic [NREQ-1:0]   req,
    input  logic [3*NREQ-1:0] sel,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   done,
    output logic              dec_a,
    output logic              dec_b,
    output logic              dec_c,
    output logic              dec_g1,
    output logic              dec_g2,
    output logic              busy
);

    localparam int IW   = $clog2(NREQ);
    localparam int CMAX = (WAIT_CYC > GAP_CYC) ? WAIT_CYC : GAP_CYC;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACTIVE,
        ST_RECOVER
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   win_q, win_d;
    logic [2:0]      sel_q, sel_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            req_hit;
    logic [IW-1:0]   pick;
    logic [2:0]      pick_sel;
    logic [IW-1:0]   scan_idx;
    int              scan;
    logic            rec_first;
    logic            strobe;

    // First set request at or after the pointer, wrapping modulo NREQ.
    always_comb begin
        req_hit  = 1'b0;
        pick     = '0;
        scan     = 0;
        scan_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan = int'(ptr_q) + k;
            if (scan >= NREQ) begin
                scan = scan - NREQ;
            end
            scan_idx = IW'(scan);
            if (!req_hit && req[scan_idx]) begin
                req_hit = 1'b1;
                pick    = scan_idx;
            end
        end
    end

    always_comb begin
        pick_sel = 3'd0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick == IW'(i)) begin
                pick_sel = sel[3*i +: 3];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_hit) begin
                    win_d   = pick;
                    sel_d   = pick_sel;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                cnt_d   = CW'(WAIT_CYC - 1);
                state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (cnt_q == '0) begin
                    cnt_d   = CW'(GAP_CYC - 1);
                    ptr_d   = (win_q == IW'(NREQ - 1)) ? '0 : win_q + 1'b1;
                    state_d = ST_RECOVER;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RECOVER: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            sel_q   <= 3'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

    // The RECOVER counter is freshly loaded on entry, so its load value marks the first cycle.
    assign rec_first = (state_q == ST_RECOVER) && (cnt_q == CW'(GAP_CYC - 1));
    assign strobe    = (state_q == ST_ACTIVE);

    always_comb begin
        grant = '0;
        done  = '0;
        for (int i = 0; i < NREQ; i++) begin
            grant[i] = ((state_q == ST_SETUP) || strobe) && (win_q == IW'(i));
            done[i]  = rec_first && (win_q == IW'(i));
        end
    end

    assign dec_a  = sel_q[0];
    assign dec_b  = sel_q[1];
    assign dec_c  = sel_q[2];
    assign dec_g1 = strobe;
    assign dec_g2 = !strobe;
    assign busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_chip_select_sched.sv
// Directed bench for chip_select_sched (NREQ=3, WAIT_CYC=2, GAP_CYC=1).
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_chip_select_sched;

    logic       clk;
    logic       rst_l;
    logic [2:0] req;
    logic [8:0] sel;
    logic [2:0] grant;
    logic [2:0] done;
    logic       dec_a, dec_b, dec_c, dec_g1, dec_g2, busy;

    int errors = 0;
    int checks = 0;

    chip_select_sched #(
        .NREQ(3),
        .WAIT_CYC(2),
        .GAP_CYC(1)
    ) dut (
        .clk(clk),
        .rst_l(rst_l),
        .req(req),
        .sel(sel),
        .grant(grant),
        .done(done),
        .dec_a(dec_a),
        .dec_b(dec_b),
        .dec_c(dec_c),
        .dec_g1(dec_g1),
        .dec_g2(dec_g2),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // 74138-style decoder output seen through the DUT's select/enable pins.
    function automatic logic [7:0] dec_out();
        logic [7:0] one;
        one = 8'd1;
        if (dec_g1 && !dec_g2) return ~(one << {dec_c, dec_b, dec_a});
        return 8'hFF;
    endfunction

    // One full access frame, starting from the falling edge before the sampling edge.
    task automatic run_access(input int idx, input logic [2:0] s,
                              input logic [2:0] req_mid, input logic [8:0] sel_mid);
        logic [2:0] oh;
        logic [7:0] one;
        logic [7:0] exp_dec;
        oh      = 3'b001 << idx;
        one     = 8'd1;
        exp_dec = ~(one << s);
        @(negedge clk);
        chk("setup_grant", 32'(grant), 32'(oh));
        chk("setup_sel",   32'({dec_c, dec_b, dec_a}), 32'(s));
        chk("setup_g1",    32'(dec_g1), 32'd0);
        chk("setup_g2",    32'(dec_g2), 32'd1);
        chk("setup_busy",  32'(busy), 32'd1);
        chk("setup_done",  32'(done), 32'd0);
        @(negedge clk);
        chk("act1_grant",  32'(grant), 32'(oh));
        chk("act1_g1",     32'(dec_g1), 32'd1);
        chk("act1_g2",     32'(dec_g2), 32'd0);
        chk("act1_dec",    32'(dec_out()), 32'(exp_dec));
        chk("act1_done",   32'(done), 32'd0);
        req = req_mid;
        sel = sel_mid;
        @(negedge clk);
        chk("act2_grant",  32'(grant), 32'(oh));
        chk("act2_dec",    32'(dec_out()), 32'(exp_dec));
        chk("act2_sel",    32'({dec_c, dec_b, dec_a}), 32'(s));
        chk("act2_done",   32'(done), 32'd0);
        @(negedge clk);
        chk("rec_grant",   32'(grant), 32'd0);
        chk("rec_done",    32'(done), 32'(oh));
        chk("rec_g1",      32'(dec_g1), 32'd0);
        chk("rec_g2",      32'(dec_g2), 32'd1);
        chk("rec_sel",     32'({dec_c, dec_b, dec_a}), 32'(s));
        chk("rec_busy",    32'(busy), 32'd1);
        @(negedge clk);
        chk("idle_busy",   32'(busy), 32'd0);
        chk("idle_done",   32'(done), 32'd0);
        chk("idle_grant",  32'(grant), 32'd0);
    endtask

    task automatic do_reset();
        rst_l = 1'b0;
        @(negedge clk);
        rst_l = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_l = 1'b0;
        req   = 3'b000;
        sel   = 9'd0;
        #3;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_done",  32'(done), 32'd0);
        chk("rst_sel",   32'({dec_c, dec_b, dec_a}), 32'd0);
        chk("rst_g1",    32'(dec_g1), 32'd0);
        chk("rst_g2",    32'(dec_g2), 32'd1);
        chk("rst_busy",  32'(busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_l = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("idle_g1",    32'(dec_g1), 32'd0);
            chk("idle_g2",    32'(dec_g2), 32'd1);
            chk("idle_grant", 32'(grant), 32'd0);
            chk("idle_busy",  32'(busy), 32'd0);
        end

        // Single access: requester 0, device 5.
        req = 3'b001;
        sel = {3'd0, 3'd0, 3'd5};
        run_access(0, 3'd5, 3'b000, {3'd0, 3'd0, 3'd5});

        // Round robin from a fresh pointer with all three requesting.
        do_reset();
        req = 3'b111;
        sel = {3'd3, 3'd2, 3'd1};
        run_access(0, 3'd1, 3'b111, {3'd3, 3'd2, 3'd1});
        run_access(1, 3'd2, 3'b111, {3'd3, 3'd2, 3'd1});
        run_access(2, 3'd3, 3'b111, {3'd3, 3'd2, 3'd1});
        run_access(0, 3'd1, 3'b000, {3'd3, 3'd2, 3'd1});

        // Pointer at 1: serve 2 alone, pointer wraps to 0, so 0 beats 1.
        req = 3'b100;
        sel = {3'd6, 3'd2, 3'd1};
        run_access(2, 3'd6, 3'b011, {3'd6, 3'd2, 3'd1});
        run_access(0, 3'd1, 3'b010, {3'd6, 3'd2, 3'd1});
        run_access(1, 3'd2, 3'b000, {3'd6, 3'd2, 3'd1});

        // sel change and req drop during ACTIVE are ignored.
        req = 3'b001;
        sel = {3'd6, 3'd2, 3'd4};
        run_access(0, 3'd4, 3'b000, {3'd6, 3'd2, 3'd7});

        // Async reset during ACTIVE aborts without done.
        req = 3'b001;
        sel = {3'd0, 3'd0, 3'd3};
        @(negedge clk);
        chk("ab_setup_grant", 32'(grant), 32'd1);
        @(negedge clk);
        chk("ab_act_g1", 32'(dec_g1), 32'd1);
        #2;
        rst_l = 1'b0;
        #1;
        chk("ab_rst_g1",    32'(dec_g1), 32'd0);
        chk("ab_rst_g2",    32'(dec_g2), 32'd1);
        chk("ab_rst_grant", 32'(grant), 32'd0);
        chk("ab_rst_done",  32'(done), 32'd0);
        chk("ab_rst_busy",  32'(busy), 32'd0);
        @(negedge clk);
        chk("ab_hold_done", 32'(done), 32'd0);
        chk("ab_hold_busy", 32'(busy), 32'd0);
        rst_l = 1'b1;
        run_access(0, 3'd3, 3'b000, {3'd0, 3'd0, 3'd3});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
